alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter FAIR, default 1; 1 = round-robin grant, 0 = fixed priority to requester 0.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 operation valid.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  32  requester 0 operands.
- req0_op  in  3  requester 0 ALU opcode.
- rsp0_valid  out  1  requester 0 result valid.
- rsp0_ready  in  1  requester 0 result consumed.
- rsp0_result  out  32  requester 0 result.
- rsp0_zero  out  1  requester 0 zero flag.
- req1_*, rsp1_*  same widths and meanings for requester 1.
- alu_a, alu_b  out  32  operands to the shared ALU.
- alu_op  out  3  opcode to the shared ALU.
- alu_out  in  32  ALU result, combinational from alu_a/alu_b/alu_op.
- alu_zero  in  1  ALU zero flag.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-004 In IDLE with at least one reqN_valid high, the block SHALL assert reqN_ready for exactly one granted requester that same cycle, latch its a/b/op into operand registers, record the grant, and go to ISSUE.
REQ-005 reqN_ready SHALL be high only in IDLE, only for the granted requester, and only while that requester's valid is high.
REQ-006 Grant with only one valid SHALL go to that requester.
REQ-007 Grant with both valid and FAIR=1 SHALL go to the requester not granted last; with FAIR=0 it SHALL go to requester 0.
REQ-008 alu_a, alu_b and alu_op SHALL be driven directly from the operand registers, and SHALL be stable from ISSUE through RESP.
REQ-009 In ISSUE, the block SHALL capture alu_out and alu_zero into the result registers and go to RESP unconditionally.
REQ-010 In RESP, rspN_valid SHALL be high for the granted requester only, with rspN_result and rspN_zero taken from the result registers.
REQ-011 In RESP, rspN_valid, result and zero SHALL be held unchanged until rspN_ready is high; on that cycle the FSM SHALL go to IDLE.
REQ-012 Latency SHALL be fixed: accept in cycle T, rspN_valid high from cycle T+2. Minimum issue interval SHALL be 3 cycles, with no accept in the cycle rspN_ready completes.
REQ-013 Opcodes SHALL be forwarded unmodified; result and zero SHALL be whatever the ALU returns (undefined opcodes yield result 0, zero 1).
REQ-014 A requester SHALL NOT receive a response it did not issue; at most one operation SHALL be outstanding.
REQ-015 rsp_ready while the corresponding rsp_valid is low SHALL be ignored.
REQ-016 busy SHALL equal (state != IDLE).

Reset
REQ-017 While rst_n is low, all outputs SHALL go low or zero immediately (asynchronous): req*_ready, rsp*_valid, rsp*_result, rsp*_zero, alu_a, alu_b, alu_op and busy.
REQ-018 While rst_n is low, state SHALL be IDLE and the last-grant record SHALL be requester 1, so requester 0 wins the first contention.
REQ-019 Reset asserted mid-operation (ISSUE or RESP) SHALL discard the operation without producing a response.
REQ-020 After rst_n deasserts, the first accept SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-021 Single ADD: req0 with a=5, b=7, op=000, accepted cycle T -> rsp0_valid at T+2, result 12, zero 0; rsp1_valid stays 0.
REQ-022 Contention after reset: req0 SUB 9,9 and req1 XOR 3,1 valid together -> req0 served first with result 0, zero 1; req1 then served with result 2, zero 0.
REQ-023 Backpressure: rsp1_ready held low 5 cycles -> rsp1_valid, rsp1_result and zero stable, req0_ready 0 and busy 1 throughout; release -> IDLE next cycle.
REQ-024 Fairness: both requesters continuously valid for 4 ops, FAIR=1 -> grant order 0,1,0,1; FAIR=0 -> 0,0,0,0.
REQ-025 Reset in RESP: rst_n low while rsp0_valid is high -> rsp0_valid and busy drop 0 without a clock; after release with both valid, requester 0 is granted.
REQ-026 Shift passthrough: SRL a=0x80000000, b=31 -> result 0x00000001; SLL a=1, b=0x21 -> result 0x00000002.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester front end for a shared combinational ALU.
//               One operation in flight at a time: accept, issue, respond.
//               Round-robin or fixed-priority grant selected by FAIR.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        busy
);

  localparam logic c_fairMode = (FAIR != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_owner;      // requester that owns the in-flight operation
  logic        r_lastGrant;  // requester granted most recently
  logic [31:0] r_opA;
  logic [31:0] r_opB;
  logic [2:0]  r_op;
  logic [31:0] r_result;
  logic        r_zero;
  logic        w_anyValid;
  logic        w_grant1;
  logic        w_accept;

  // State register; reset parks the FSM in IDLE, dropping any in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Grant decision: requester 1 wins alone, or on contention when fair and 0 went last
  always_comb begin
    w_anyValid = req0_valid | req1_valid;
    w_grant1   = req1_valid & (~req0_valid | (c_fairMode & ~r_lastGrant));
  end

  // Next-state and handshake outputs; ready is gated by rst_n so it stays low during reset
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n && w_anyValid) begin
          w_accept    = 1'b1;
          req0_ready  = ~w_grant1;
          req1_ready  = w_grant1;
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        w_nextState = RESP;
      end
      RESP: begin
        rsp0_valid = ~r_owner;
        rsp1_valid = r_owner;
        if (r_owner ? rsp1_ready : rsp0_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Operand capture and grant bookkeeping on accept; last grant resets to 1 so 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= 1'b0;
      r_lastGrant <= 1'b1;
      r_opA       <= '0;
      r_opB       <= '0;
      r_op        <= '0;
    end else if (w_accept) begin
      r_owner     <= w_grant1;
      r_lastGrant <= w_grant1;
      r_opA       <= w_grant1 ? req1_a  : req0_a;
      r_opB       <= w_grant1 ? req1_b  : req0_b;
      r_op        <= w_grant1 ? req1_op : req0_op;
    end
  end

  // Result capture: the ALU has settled on the operand registers by ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (r_state == ISSUE) begin
      r_result <= alu_out;
      r_zero   <= alu_zero;
    end
  end

  assign alu_a       = r_opA;
  assign alu_b       = r_opB;
  assign alu_op      = r_op;
  assign busy        = (r_state != IDLE);
  assign rsp0_result = rsp0_valid ? r_result : '0;
  assign rsp0_zero   = rsp0_valid & r_zero;
  assign rsp1_result = rsp1_valid ? r_result : '0;
  assign rsp1_zero   = rsp1_valid & r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter (FAIR=1 and FAIR=0 copies
//               sharing stimulus), with a reference ALU and transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic req0Valid, req1Valid, rsp0Ready, rsp1Ready;
  logic [31:0] req0A, req0B, req1A, req1B;
  logic [2:0]  req0Op, req1Op;

  logic fReq0Ready, fReq1Ready, fRsp0Valid, fRsp1Valid, fRsp0Zero, fRsp1Zero, fAluZero, fBusy;
  logic [31:0] fRsp0Result, fRsp1Result, fAluA, fAluB, fAluOut;
  logic [2:0]  fAluOp;
  logic pReq0Ready, pReq1Ready, pRsp0Valid, pRsp1Valid, pRsp0Zero, pRsp1Zero, pAluZero, pBusy;
  logic [31:0] pRsp0Result, pRsp1Result, pAluA, pAluB, pAluOut;
  logic [2:0]  pAluOp;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 undefined
  function automatic logic [32:0] aluRef(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [31:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[4:0];
      3'd6: r = a >> b[4:0];
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  assign {fAluZero, fAluOut} = aluRef(fAluA, fAluB, fAluOp);
  assign {pAluZero, pAluOut} = aluRef(pAluA, pAluB, pAluOp);

  alu_arbiter #(.FAIR(1)) dutFair (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0Valid), .req0_ready(fReq0Ready), .req0_a(req0A), .req0_b(req0B), .req0_op(req0Op),
    .rsp0_valid(fRsp0Valid), .rsp0_ready(rsp0Ready), .rsp0_result(fRsp0Result), .rsp0_zero(fRsp0Zero),
    .req1_valid(req1Valid), .req1_ready(fReq1Ready), .req1_a(req1A), .req1_b(req1B), .req1_op(req1Op),
    .rsp1_valid(fRsp1Valid), .rsp1_ready(rsp1Ready), .rsp1_result(fRsp1Result), .rsp1_zero(fRsp1Zero),
    .alu_a(fAluA), .alu_b(fAluB), .alu_op(fAluOp), .alu_out(fAluOut), .alu_zero(fAluZero),
    .busy(fBusy)
  );

  alu_arbiter #(.FAIR(0)) dutPrio (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0Valid), .req0_ready(pReq0Ready), .req0_a(req0A), .req0_b(req0B), .req0_op(req0Op),
    .rsp0_valid(pRsp0Valid), .rsp0_ready(rsp0Ready), .rsp0_result(pRsp0Result), .rsp0_zero(pRsp0Zero),
    .req1_valid(req1Valid), .req1_ready(pReq1Ready), .req1_a(req1A), .req1_b(req1B), .req1_op(req1Op),
    .rsp1_valid(pRsp1Valid), .rsp1_ready(rsp1Ready), .rsp1_result(pRsp1Result), .rsp1_zero(pRsp1Zero),
    .alu_a(pAluA), .alu_b(pAluB), .alu_op(pAluOp), .alu_out(pAluOut), .alu_zero(pAluZero),
    .busy(pBusy)
  );

  typedef struct {
    int          who;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        zero;
    string       name;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic fReady(input int w);
    return (w != 0) ? fReq1Ready : fReq0Ready;
  endfunction

  function automatic logic fRspValid(input int w);
    return (w != 0) ? fRsp1Valid : fRsp0Valid;
  endfunction

  function automatic logic [31:0] fRspResult(input int w);
    return (w != 0) ? fRsp1Result : fRsp0Result;
  endfunction

  function automatic logic fRspZero(input int w);
    return (w != 0) ? fRsp1Zero : fRsp0Zero;
  endfunction

  task automatic driveReq(input int w, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (w != 0) begin
      req1Valid = v; req1A = a; req1B = b; req1Op = op;
    end else begin
      req0Valid = v; req0A = a; req0B = b; req0Op = op;
    end
  endtask

  task automatic setRspReady(input int w, input logic v);
    if (w != 0) rsp1Ready = v;
    else        rsp0Ready = v;
  endtask

  // Caller sits one time step after the first negedge following the accept edge
  task automatic waitRsp(input int w, output int lat);
    lat = 1;
    while (!fRspValid(w) && lat < 12) begin
      @(negedge clk); #1;
      lat++;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runVector(input vec_t v);
    int waited;
    int lat;
    @(negedge clk);
    driveReq(v.who, 1'b1, v.a, v.b, v.op);
    #1;
    waited = 0;
    while (!fReady(v.who) && waited < 12) begin
      @(negedge clk); #1;
      waited++;
    end
    chk({v.name, " accepted"}, 32'(fReady(v.who)), 32'd1);
    @(negedge clk);
    driveReq(v.who, 1'b0, 32'd0, 32'd0, 3'd0);
    #1;
    waitRsp(v.who, lat);
    chk({v.name, " latency"}, 32'(lat), 32'd2);
    chk({v.name, " result"}, fRspResult(v.who), v.res);
    chk({v.name, " zero"}, 32'(fRspZero(v.who)), 32'(v.zero));
    chk({v.name, " other rsp_valid"}, 32'(fRspValid(1 - v.who)), 32'd0);
    chk({v.name, " alu_op forwarded"}, 32'(fAluOp), 32'(v.op));
    setRspReady(v.who, 1'b1);
    @(negedge clk); #1;
    setRspReady(v.who, 1'b0);
    chk({v.name, " back to idle"}, 32'(fBusy), 32'd0);
  endtask

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int gotF[$];
    int gotP[$];
    int expF[4];
    bit mBusy;
    int mOwner, mAge, mLast, g;
    logic [31:0] mRes;
    logic mZero;

    vecs[0] = '{0, 32'd5,          32'd7,          3'd0, 32'd12,         1'b0, "ADD 5+7"};
    vecs[1] = '{1, 32'h8000_0000,  32'd31,         3'd6, 32'h0000_0001,  1'b0, "SRL"};
    vecs[2] = '{0, 32'd1,          32'h21,         3'd5, 32'h0000_0002,  1'b0, "SLL"};
    vecs[3] = '{1, 32'd9,          32'd9,          3'd1, 32'd0,          1'b1, "SUB 9-9"};
    vecs[4] = '{0, 32'd123,        32'd4,          3'd7, 32'd0,          1'b1, "undefined op"};
    vecs[5] = '{1, 32'h0000_F0F0,  32'h0000_0FF0,  3'd2, 32'h0000_00F0,  1'b0, "AND"};
    vecs[6] = '{0, 32'd1,          32'd2,          3'd3, 32'd3,          1'b0, "OR"};

    rst_n = 1'b0;
    req0Valid = 1'b1; req1Valid = 1'b1;
    req0A = '0; req0B = '0; req0Op = '0;
    req1A = '0; req1B = '0; req1Op = '0;
    rsp0Ready = 1'b1; rsp1Ready = 1'b1;

    // Reset state, with valids high to expose ungated ready
    #12;
    chk("reset req0_ready", 32'(fReq0Ready), 32'd0);
    chk("reset req1_ready", 32'(fReq1Ready), 32'd0);
    chk("reset busy", 32'(fBusy), 32'd0);
    chk("reset rsp0_valid", 32'(fRsp0Valid), 32'd0);
    chk("reset alu_a", fAluA, 32'd0);
    chk("reset prio busy", 32'(pBusy), 32'd0);
    req0Valid = 1'b0; req1Valid = 1'b0;
    rsp0Ready = 1'b0; rsp1Ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single-requester vectors
    foreach (vecs[i]) runVector(vecs[i]);

    // Contention after reset, then backpressure on requester 1
    doReset();
    driveReq(0, 1'b1, 32'd9, 32'd9, 3'd1);
    driveReq(1, 1'b1, 32'd3, 32'd1, 3'd4);
    #1;
    chk("contention req0 granted", 32'(fReq0Ready), 32'd1);
    chk("contention req1 waits", 32'(fReq1Ready), 32'd0);
    @(negedge clk);
    req0Valid = 1'b0;
    #1;
    waitRsp(0, lat);
    chk("contention rsp0 latency", 32'(lat), 32'd2);
    chk("contention rsp0 result", fRsp0Result, 32'd0);
    chk("contention rsp0 zero", 32'(fRsp0Zero), 32'd1);
    chk("contention rsp1 idle", 32'(fRsp1Valid), 32'd0);
    rsp0Ready = 1'b1;
    @(negedge clk);
    rsp0Ready = 1'b0;
    #1;
    chk("contention req1 granted next", 32'(fReq1Ready), 32'd1);
    @(negedge clk);
    req1Valid = 1'b0;
    driveReq(0, 1'b1, 32'd10, 32'd20, 3'd0);
    #1;
    waitRsp(1, lat);
    chk("contention rsp1 latency", 32'(lat), 32'd2);
    for (int c = 0; c < 5; c++) begin
      chk("backpressure rsp1_valid", 32'(fRsp1Valid), 32'd1);
      chk("backpressure rsp1_result", fRsp1Result, 32'd2);
      chk("backpressure rsp1_zero", 32'(fRsp1Zero), 32'd0);
      chk("backpressure req0_ready", 32'(fReq0Ready), 32'd0);
      chk("backpressure busy", 32'(fBusy), 32'd1);
      @(negedge clk); #1;
    end
    rsp1Ready = 1'b1;
    @(negedge clk);
    rsp1Ready = 1'b0;
    #1;
    chk("release idle", 32'(fBusy), 32'd0);
    chk("release req0 ready", 32'(fReq0Ready), 32'd1);
    @(negedge clk);
    req0Valid = 1'b0;
    #1;
    waitRsp(0, lat);
    chk("post-release rsp0 result", fRsp0Result, 32'd30);
    rsp0Ready = 1'b1;
    @(negedge clk);
    rsp0Ready = 1'b0;

    // Fairness: both continuously valid
    doReset();
    driveReq(0, 1'b1, 32'd1, 32'd1, 3'd0);
    driveReq(1, 1'b1, 32'd2, 32'd2, 3'd0);
    rsp0Ready = 1'b1; rsp1Ready = 1'b1;
    #1;
    for (int c = 0; c < 30 && (gotF.size() < 4 || gotP.size() < 4); c++) begin
      if (fReq0Ready && gotF.size() < 4) gotF.push_back(0);
      if (fReq1Ready && gotF.size() < 4) gotF.push_back(1);
      if (pReq0Ready && gotP.size() < 4) gotP.push_back(0);
      if (pReq1Ready && gotP.size() < 4) gotP.push_back(1);
      @(negedge clk); #1;
    end
    chk("fair grant count", 32'(gotF.size()), 32'd4);
    chk("prio grant count", 32'(gotP.size()), 32'd4);
    expF = '{0, 1, 0, 1};
    for (int k = 0; k < 4; k++) begin
      if (k < gotF.size()) chk("fair grant order", 32'(gotF[k]), 32'(expF[k]));
      if (k < gotP.size()) chk("prio grant order", 32'(gotP[k]), 32'd0);
    end
    req0Valid = 1'b0; req1Valid = 1'b0;
    for (int c = 0; c < 10 && (fBusy || pBusy); c++) begin
      @(negedge clk); #1;
    end
    rsp0Ready = 1'b0; rsp1Ready = 1'b0;

    // Reset in RESP: last grant was 0, yet 0 must win after reset
    @(negedge clk);
    driveReq(0, 1'b1, 32'd1, 32'd2, 3'd0);
    #1;
    chk("pre-reset req0 ready", 32'(fReq0Ready), 32'd1);
    @(negedge clk);
    req0Valid = 1'b0;
    #1;
    waitRsp(0, lat);
    chk("pre-reset rsp0 valid", 32'(fRsp0Valid), 32'd1);
    req0Valid = 1'b1; req1Valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset rsp0_valid", 32'(fRsp0Valid), 32'd0);
    chk("async reset busy", 32'(fBusy), 32'd0);
    chk("async reset rsp0_result", fRsp0Result, 32'd0);
    chk("async reset alu_a", fAluA, 32'd0);
    chk("async reset req0_ready", 32'(fReq0Ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("after reset req0 granted", 32'(fReq0Ready), 32'd1);
    chk("after reset req1 waits", 32'(fReq1Ready), 32'd0);
    req0Valid = 1'b0; req1Valid = 1'b0;
    rsp0Ready = 1'b1; rsp1Ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
    end

    // Randomized traffic against a transaction-level model
    doReset();
    mBusy = 1'b0; mOwner = 0; mAge = 0; mLast = 1; mRes = '0; mZero = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      req0Valid = ($urandom_range(0, 2) != 0);
      req1Valid = ($urandom_range(0, 2) != 0);
      req0A = $urandom; req0B = $urandom; req0Op = 3'($urandom_range(0, 7));
      req1A = $urandom; req1B = $urandom; req1Op = 3'($urandom_range(0, 7));
      rsp0Ready = ($urandom_range(0, 1) != 0);
      rsp1Ready = ($urandom_range(0, 1) != 0);
      #1;
      g = -1;
      if (!mBusy && (req0Valid || req1Valid)) begin
        if (req0Valid && req1Valid) g = (mLast == 0) ? 1 : 0;
        else                        g = req1Valid ? 1 : 0;
      end
      chk("rand req0_ready", 32'(fReq0Ready), 32'(g == 0));
      chk("rand req1_ready", 32'(fReq1Ready), 32'(g == 1));
      chk("rand busy", 32'(fBusy), 32'(mBusy));
      chk("rand rsp0_valid", 32'(fRsp0Valid), 32'(mBusy && mAge >= 2 && mOwner == 0));
      chk("rand rsp1_valid", 32'(fRsp1Valid), 32'(mBusy && mAge >= 2 && mOwner == 1));
      if (mBusy && mAge >= 2) begin
        chk("rand result", fRspResult(mOwner), mRes);
        chk("rand zero", 32'(fRspZero(mOwner)), 32'(mZero));
      end
      if (g >= 0) begin
        mBusy = 1'b1; mOwner = g; mAge = 1; mLast = g;
        {mZero, mRes} = (g == 1) ? aluRef(req1A, req1B, req1Op) : aluRef(req0A, req0B, req0Op);
      end else if (mBusy) begin
        if (mAge >= 2 && ((mOwner == 1) ? rsp1Ready : rsp0Ready)) mBusy = 1'b0;
        else if (mAge < 2) mAge++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
